// File: rtl/sdpsram_be.sv
// Simple dual-port byte-masked SRAM with a clear engine. Read latency is RD_LAT cycles.
// No backpressure: while a clear is running, write and read requests are dropped.
module sdpsram_be #(
  parameter int BW_DATA  = 32,
  parameter int BW_ADDR  = 5,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_wr_en,
  input  logic [BW_ADDR-1:0]   i_wr_addr,
  input  logic [BW_DATA-1:0]   i_wr_data,
  input  logic [BW_DATA/8-1:0] i_wr_be,
  input  logic                 i_rd_en,
  input  logic [BW_ADDR-1:0]   i_rd_addr,
  output logic [BW_DATA-1:0]   o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_clr,
  output logic                 o_busy
);

  localparam int DEPTH = 2 ** BW_ADDR;
  localparam int NB    = BW_DATA / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  generate
    if (RD_LAT < 1 || RD_LAT > 3 || (BW_DATA % 8) != 0) begin : g_param_err
      $error("sdpsram_be: RD_LAT must be 1..3 and BW_DATA a multiple of 8");
    end
  endgenerate

  logic [BW_DATA-1:0] mem [DEPTH];
  logic [0:0]         state;
  logic [BW_ADDR-1:0] clr_cnt;
  logic               idle;
  logic               wr_acc;
  logic               rd_acc;
  logic [BW_DATA-1:0] rd_word;

  assign idle   = (state == ST_IDLE);
  assign wr_acc = i_wr_en & idle;
  assign rd_acc = i_rd_en & idle;
  assign o_busy = (state == ST_CLEAR);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_clr) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          // Counter wraps to zero on the last word, leaving it ready for the next clear.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {BW_ADDR{1'b1}}) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset; contents survive i_rstn.
  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[i_rd_addr];
    if (RDW_MODE == 1 && wr_acc && (i_wr_addr == i_rd_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) rd_word[8*k +: 8] = i_wr_data[8*k +: 8];
      end
    end
  end

  logic [RD_LAT-1:0]  vld_pipe;
  logic [BW_DATA-1:0] dat_pipe [RD_LAT];

  // Data stages only load alongside a valid so the output holds between strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) dat_pipe[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign o_rd_valid = vld_pipe[RD_LAT-1];
  assign o_rd_data  = dat_pipe[RD_LAT-1];

endmodule

// File: tb/tb_sdpsram_be.sv
// Bench for sdpsram_be: three instances (latency 1/2/3, write-through on the latency-2 one)
// share one stimulus stream and are checked every cycle against a behavioural memory model.
module tb_sdpsram_be;

  localparam int LAT  [3] = '{1, 2, 3};
  localparam int MODE [3] = '{0, 1, 0};

  logic        clk;
  logic        rstn;
  logic        wr_en, rd_en, clr;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_dat [3];
  logic        rd_vld [3];
  logic        busy   [3];

  int errors = 0;
  int checks = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      sdpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(LAT[g]), .RDW_MODE(MODE[g])) u_dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_wr_be    (wr_be),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_dat[g]),
        .o_rd_valid (rd_vld[g]),
        .i_clr      (clr),
        .o_busy     (busy[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [32];
  logic        mbusy;
  int          mcnt;
  int unsigned ecnt = 0;
  logic [31:0] sched [3][int unsigned];  // expected read data keyed by the edge after which it shows
  logic [31:0] last  [3];

  always @(posedge clk or negedge rstn) begin
    logic [31:0] w;
    if (!rstn) begin
      mbusy = 1'b0;
      mcnt  = 0;
      for (int i = 0; i < 3; i++) sched[i].delete();
    end else begin
      ecnt++;
      if (!mbusy) begin
        if (rd_en) begin
          for (int i = 0; i < 3; i++) begin
            w = mmem[rd_addr];
            if (MODE[i] == 1 && wr_en && wr_addr == rd_addr)
              for (int k = 0; k < 4; k++) if (wr_be[k]) w[8*k +: 8] = wr_data[8*k +: 8];
            sched[i][ecnt + LAT[i] - 1] = w;
          end
        end
        if (wr_en)
          for (int k = 0; k < 4; k++) if (wr_be[k]) mmem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
        if (clr) begin
          mbusy = 1'b1;
          mcnt  = 0;
        end
      end else begin
        mmem[mcnt] = 32'h0;
        mcnt++;
        if (mcnt == 32) begin
          mbusy = 1'b0;
          mcnt  = 0;
        end
      end
    end
  end

  always @(negedge clk or negedge rstn) begin
    logic ev;
    if (!rstn) begin
      for (int i = 0; i < 3; i++) last[i] = 32'h0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ev = sched[i].exists(ecnt);
        if (ev) last[i] = sched[i][ecnt];
        chk($sformatf("valid[L%0d]", LAT[i]), {31'b0, rd_vld[i]}, {31'b0, ev});
        chk($sformatf("data[L%0d]", LAT[i]), rd_dat[i], last[i]);
        chk($sformatf("busy[L%0d]", LAT[i]), {31'b0, busy[i]}, {31'b0, mbusy});
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic idle_in();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill(input logic [31:0] d, input bit use_addr);
    for (int a = 0; a < 32; a++) wr(5'(a), use_addr ? 32'(a) : d, 4'hF);
  endtask

  task automatic rd_all();
    for (int a = 0; a < 32; a++) begin
      rd_en = 1'b1; rd_addr = 5'(a);
      @(negedge clk);
    end
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Read (optionally with a same-edge write) and check each instance at its own latency.
  task automatic op_lit(input string nm, input logic [4:0] ra, input logic do_wr,
                        input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    rd_en = 1'b1; rd_addr = ra;
    wr_en = do_wr; wr_addr = wa; wr_data = wd; wr_be = be;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_in();
      chk($sformatf("%s valid L%0d", nm, LAT[i]), {31'b0, rd_vld[i]}, 32'd1);
      chk($sformatf("%s data L%0d", nm, LAT[i]), rd_dat[i], e[i]);
    end
  endtask

  task automatic wait_clear(input string nm);
    int bc;
    int guard;
    bc = busy[0] ? 1 : 0;
    guard = 0;
    while (busy[0] && guard < 100) begin
      wr_en = 1'b1; wr_addr = 5'($urandom_range(31)); wr_data = 32'h5555_5555; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 5'($urandom_range(31));
      @(negedge clk);
      idle_in();
      guard++;
      if (busy[0]) bc++;
    end
    chk(nm, 32'(bc), 32'd32);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vc;
    rstn = 1'b0; idle_in(); wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset valid", {31'b0, rd_vld[i]}, 32'd0);
      chk("reset data", rd_dat[i], 32'd0);
      chk("reset busy", {31'b0, busy[i]}, 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // byte mask
    wr(5'd3, 32'hAABB_CCDD, 4'hF);
    wr(5'd3, 32'h1122_3344, 4'b0101);
    op_lit("T2 byte mask", 5'd3, 1'b0, 5'd0, 32'h0, 4'h0,
           32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44);

    // collision, then non-colliding write and an all-zero byte enable
    wr(5'd5, 32'h0, 4'hF);
    op_lit("T4 collision", 5'd5, 1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF,
           32'h0, 32'hFFFF_FFFF, 32'h0);
    op_lit("T4 after", 5'd5, 1'b1, 5'd6, 32'h1234_5678, 4'hF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(5'd6, 32'hDEAD_0000, 4'h0);
    op_lit("be0 noop", 5'd6, 1'b0, 5'd0, 32'h0, 4'h0,
           32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

    // streaming
    fill(32'h0, 1'b1);
    vc = 0;
    for (int a = 0; a < 32; a++) begin
      rd_en = 1'b1; rd_addr = 5'(a);
      @(negedge clk);
      if (rd_vld[0] && rd_dat[0] == 32'(a)) vc++;
    end
    rd_en = 1'b0;
    chk("T3 in-order valids L1", 32'(vc), 32'd32);
    repeat (3) @(negedge clk);

    // asynchronous reset with reads in flight
    for (int j = 0; j < 6; j++) begin
      rd_en = 1'b1; rd_addr = 5'(20 + j);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    chk("T1 pre-reset valid L3", {31'b0, rd_vld[2]}, 32'd1);
    rstn = 1'b0; rd_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("T1 async valid", {31'b0, rd_vld[i]}, 32'd0);
      chk("T1 async data", rd_dat[i], 32'd0);
      chk("T1 async busy", {31'b0, busy[i]}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // clear
    fill(32'hDEAD_BEEF, 1'b0);
    pulse_clr();
    wait_clear("T5 busy cycles");
    rd_all();
    op_lit("T5 cleared", 5'd17, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);

    // reset mid-clear
    fill(32'hDEAD_BEEF, 1'b0);
    pulse_clr();
    repeat (10) @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("T6 busy after reset", {31'b0, busy[0]}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("T6 model addr10", mmem[10], 32'hDEAD_BEEF);
    op_lit("T6 addr9", 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    op_lit("T6 addr10", 5'd10, 1'b0, 5'd0, 32'h0, 4'h0,
           32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    rd_all();
    pulse_clr();
    wait_clear("T6 reclear busy cycles");
    op_lit("T6 reclear addr31", 5'd31, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    rd_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
